// File: rtl/prog_mem_loader.sv
// Boot loader: receives a length-prefixed byte image and writes it
// word by word into program memory while holding the core.
module prog_mem_loader #(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 2048,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state;
  logic [1:0]     byte_cnt;
  logic [31:0]    shreg;
  logic [31:0]    n_words;
  logic [31:0]    word_cnt;
  logic [TW-1:0]  idle_cnt;
  logic           xfer;
  logic           active;
  logic           timeout_hit;
  logic           last_word;
  logic [31:0]    hdr_word;
  logic [31:0]    data_word;

  assign xfer        = in_valid & in_ready;
  assign active      = (state == S_HDR) || (state == S_DATA);
  assign timeout_hit = !xfer && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign last_word   = (word_cnt + 32'd1) == n_words;
  // header is little-endian, data words are first-byte-most-significant
  assign hdr_word    = {in_data, shreg[31:8]};
  assign data_word   = {shreg[23:0], in_data};

  always_ff @(posedge clk) begin
    if (rst || !active || xfer) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      byte_cnt <= '0;
      shreg    <= '0;
      n_words  <= '0;
      word_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HDR;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            err      <= 1'b0;
            byte_cnt <= '0;
            word_cnt <= '0;
            shreg    <= '0;
          end
        end
        S_HDR: begin
          if (timeout_hit) begin
            state    <= S_ERR;
            err      <= 1'b1;
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
          end else if (xfer) begin
            shreg    <= hdr_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              n_words <= hdr_word;
              if (hdr_word == 32'd0) begin
                state    <= S_DONE;
                done     <= 1'b1;
                in_ready <= 1'b0;
                cpu_hold <= 1'b0;
              end else if (hdr_word > 32'(MEM_DEPTH)) begin
                state    <= S_ERR;
                err      <= 1'b1;
                in_ready <= 1'b0;
                cpu_hold <= 1'b0;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          // in_ready low here means the final word is being written
          if (!in_ready) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (timeout_hit) begin
            state    <= S_ERR;
            err      <= 1'b1;
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
          end else if (xfer) begin
            shreg    <= data_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= {word_cnt[ADDR_WIDTH-3:0], 2'b00};
              wr_data  <= DATA_WIDTH'(data_word);
              word_cnt <= word_cnt + 32'd1;
              if (last_word) begin
                in_ready <= 1'b0;
              end
            end
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized image loads checked against a queue-based model
// of the expected memory writes and session outcome.
module tb_prog_mem_loader;

  localparam int AW = 13;
  localparam int MD = 2048;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  prog_mem_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(32),
    .MEM_DEPTH(MD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  logic [44:0] exp_q[$];
  logic [44:0] mon_e;
  logic [7:0]  none[$];
  logic [7:0]  d1[$];
  int          cyc = 0;
  int          last_wr = 0;
  int          n_wr = 0;
  int          n_done = 0;
  bit          full_rate = 0;

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("spurious_wr", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", wr_addr, mon_e[44:32]);
        chk("wr_data", wr_data, mon_e[31:0]);
      end
      chk("hold_on_wr", cpu_hold, 1);
      if (full_rate && n_wr > 0) chk("wr_spacing", cyc - last_wr, 4);
      last_wr = cyc;
      n_wr++;
    end
    if (done) begin
      n_done++;
      if (n_wr > 0) chk("done_lat", cyc - last_wr, 1);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap, output int stall);
    bit sent = 0;
    stall = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 200 && !sent; t++) begin
      if (in_ready) sent = 1;
      else stall++;
      @(negedge clk);
    end
    if (!sent) chk("rdy_timeout", 0, 1);
  endtask

  task automatic wait_end(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done || err) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk("end_timeout", 0, 1);
    chk("end_hold", cpu_hold, 0);
    chk("end_rdy", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic session(input int n, input int gapmax, input bit fr,
                         input logic [7:0] img[$]);
    logic [31:0] nn;
    logic [7:0]  dat[$];
    int          st;
    int          stalls;
    nn = n;
    dat = img;
    if (n <= MD && dat.size() == 0)
      for (int i = 0; i < 4 * n; i++) dat.push_back(8'($urandom));
    if (n <= MD)
      for (int k = 0; k < n; k++)
        exp_q.push_back({AW'(k * 4), dat[4*k], dat[4*k+1],
                         dat[4*k+2], dat[4*k+3]});
    else dat = {};
    full_rate = fr;
    n_wr = 0;
    n_done = 0;
    stalls = 0;
    pulse_start();
    chk("hold_hdr", cpu_hold, 1);
    chk("err_clr", err, 0);
    for (int i = 0; i < 4; i++) begin
      send(nn[8*i +: 8], fr ? 0 : $urandom_range(0, gapmax), st);
      stalls += st;
    end
    foreach (dat[i]) begin
      send(dat[i], fr ? 0 : $urandom_range(0, gapmax), st);
      stalls += st;
    end
    in_valid = 1'b0;
    wait_end(100);
    chk("sess_err", err, n > MD);
    chk("sess_done", n_done, n > MD ? 0 : 1);
    chk("sess_nwr", n_wr, n > MD ? 0 : n);
    chk("sess_q", exp_q.size(), 0);
    if (fr) chk("no_stall", stalls, 0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("beyond_rdy", in_ready, 0);
    in_valid = 1'b0;
    full_rate = 0;
  endtask

  initial begin
    int st;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset", {in_ready, wr_en, cpu_hold, done, err, wr_addr, wr_data}, 0);

    d1 = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    session(2, 2, 0, d1);
    session(0, 2, 0, none);
    session(MD + 1, 2, 0, none);
    session(1, 1, 0, none);

    // timeout mid-word
    n_wr = 0;
    n_done = 0;
    pulse_start();
    send(8'h01, 0, st);
    for (int i = 0; i < 5; i++) send(8'h00, 0, st);
    in_valid = 1'b0;
    wait_end(TO + 20);
    chk("to_err", err, 1);
    chk("to_nwr", n_wr, 0);
    chk("to_done", n_done, 0);

    session(3, 0, 1, none);
    for (int r = 0; r < 6; r++) session($urandom_range(1, 6), 3, 0, none);

    // reset mid-session, start during DATA ignored
    n_wr = 0;
    n_done = 0;
    d1 = '{8'hde, 8'had, 8'hbe, 8'hef};
    exp_q.push_back({AW'(0), 32'hdeadbeef});
    pulse_start();
    send(8'h02, 0, st);
    for (int i = 0; i < 3; i++) send(8'h00, 0, st);
    foreach (d1[i]) send(d1[i], 0, st);
    start = 1'b1;
    send(8'h55, 0, st);
    start = 1'b0;
    in_valid = 1'b0;
    chk("start_ign", {cpu_hold, in_ready, err}, 3'b110);
    chk("rst_nwr", n_wr, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid", {in_ready, wr_en, cpu_hold, done, err, wr_addr, wr_data}, 0);
    @(negedge clk);
    chk("rst_nodone", n_done, 0);
    session(2, 1, 0, none);

    session(MD, 0, 1, none);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
